shared_bus_controller: RTL and testbench
========================================

Name: shared_bus_controller

Overview:
- Downstream of the dual-core bus arbiter: consumes grant1/grant2 and executes one shared-memory transaction for the granted core.
- Muxes the owner's address, write-enable and write data onto the single memory port, and waits for memory ready.
- Returns an ack, plus read data, to the owner only.
- Drives the arbiter's enable so grants stay frozen while a transaction is in flight.

Parameters:
- ADDR_W, 8, address width of core and memory ports.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with BUS_TIMEOUT_EN); must be >= 1.

Ports:
- clk input 1: rising-edge clock.
- reset input 1: synchronous, active-high.
- grant1, grant2 input 1 each: arbiter grants.
- arb_enable output 1: high only in IDLE; holds the arbiter decision otherwise.
- p1_req, p2_req input 1 each: level request, held until ack.
- p1_we, p2_we input 1 each: 1 = write, 0 = read.
- p1_addr, p2_addr input ADDR_W each.
- p1_wdata, p2_wdata input DATA_W each.
- p1_ack, p2_ack output 1 each: one-cycle completion pulse.
- p1_rdata, p2_rdata output DATA_W each: read data, valid with ack.
- bus_err output 1: pulse with ack on timeout abort.
- mem_req output 1: one-cycle command strobe.
- mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W.
- mem_rdata input DATA_W; mem_ready input 1.
- bus_owner output 2: 00 none, 01 P1, 10 P2.

Behaviour:
- Reset values:
  - state = IDLE, arb_enable = 1.
  - All other outputs 0: acks, rdata, bus_err, mem_* , bus_owner.
  - Reset mid-transaction abandons it: no ack, mem_req drops next edge.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If grant1 & p1_req: owner = P1.
  - Else if grant2 & p2_req: owner = P2.
  - grant1 & grant2 both high: P1 wins.
  - On accept, latch owner's we/addr/wdata into internal registers and go to ISSUE.
  - A grant without the matching req accepts nothing.
- ISSUE:
  - mem_req = 1 for exactly one cycle.
  - mem_we/addr/wdata come from the latched registers, stable from ISSUE through RESP.
  - mem_ready is ignored in ISSUE.
  - Next state WAIT.
- WAIT:
  - Stays until mem_ready = 1 is sampled.
  - On a read, captures mem_rdata into the owner's rdata register; on a write, rdata is unchanged.
  - Next state RESP.
- RESP:
  - Owner's ack = 1 for one cycle; the non-owner's ack stays 0. Next state IDLE.
  - Requesters deassert req on the same edge ack is sampled. A req still high in the following IDLE is a new request.
- Latency: accept at cycle 0 -> mem_req at cycle 1 -> ready earliest cycle 2 -> ack at cycle 3. Each ready-wait cycle adds 1.
- bus_owner is valid in ISSUE through RESP and 00 in IDLE.
- arb_enable = (state == IDLE). Request changes outside IDLE never alter the owner.
- Back-to-back: minimum 4 cycles per transaction; the bus is never idle between them if requests are pending.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A WAIT counter starts at 0 on entry.
  - If it reaches TIMEOUT without mem_ready, go to RESP with bus_err = 1 alongside the ack; rdata is unchanged.
  - mem_ready on the same cycle the counter hits TIMEOUT counts as success.
- Not defined: WAIT is unbounded, no counter logic exists, and bus_err is tied 0.

Decomposition:
- Shared package/include bus_defs: BUS_GRANTED/BUS_NOT_GRANTED, BUS_REQUESTED/BUS_NOT_REQUESTED, state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), owner codes.
- One sub-module, bus_timeout_counter: clear/enable/expire, parameter TIMEOUT. Instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- P1 read, addr 0x3A, mem_ready on the first WAIT cycle with rdata 0xBEEF:
  - mem_req at cycle 1 with addr 0x3A and we = 0.
  - p1_ack and p1_rdata = 0xBEEF at cycle 3; p2_ack stays 0.
- P2-only write, addr 0x10, wdata 0x1234, ready delayed 3 cycles:
  - mem_we = 1 and mem_wdata = 0x1234 are held stable.
  - p2_ack at cycle 6; arb_enable is 0 during cycles 1-6.
- Both request: P1 is served first.
  - P2 holds req; P2 is accepted in the IDLE after P1's ack.
  - bus_owner sequence is 01 then 10, and P2's mem_req is no earlier than 4 cycles after P1's.
- Reset asserted in WAIT:
  - Next cycle: IDLE, mem_req = 0, no ack, arb_enable = 1.
  - Subsequent transactions complete normally.
- BUS_TIMEOUT_EN with TIMEOUT = 4 and mem_ready never asserted:
  - Ack with bus_err = 1 exactly 4 WAIT cycles after entry.
  - Rdata is unchanged.
- P1 request changes in WAIT (addr toggled) while grant1 is held:
  - mem_addr keeps the latched value.
  - Exactly one ack is produced.

Source files
------------

// File: rtl/bus_defs_pkg.sv
// Shared definitions for the shared-memory bus controller: grant/request levels,
// FSM state encoding and bus owner codes.
package bus_defs_pkg;

    typedef enum logic {
        BUS_NOT_GRANTED = 1'b0,
        BUS_GRANTED     = 1'b1
    } grant_e;

    typedef enum logic {
        BUS_NOT_REQUESTED = 1'b0,
        BUS_REQUESTED     = 1'b1
    } request_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P1   = 2'b01,
        OWN_P2   = 2'b10
    } owner_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive WAIT cycles and flags the TIMEOUT-th one so the controller
// can abort a memory access that never completes.
module bus_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // count_q holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th cycle is the one where count_q equals TIMEOUT-1.
    logic [CNT_W-1:0] count_q;

    assign expire_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expire_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/shared_bus_controller.sv
// Executes one shared-memory transaction for the core granted by the arbiter.
// Define BUS_TIMEOUT_EN to bound WAIT to TIMEOUT cycles and flag aborts on bus_err.
module shared_bus_controller
    import bus_defs_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant1,
    input  logic              grant2,
    output logic              arb_enable,
    input  logic              p1_req,
    input  logic              p2_req,
    input  logic              p1_we,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p1_ack,
    output logic              p2_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        bus_owner
);

    state_e              state_q;
    owner_e              owner_q;
    logic                arb_enable_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                p1_ack_q;
    logic                p2_ack_q;
    logic [DATA_W-1:0]   p1_rdata_q;
    logic [DATA_W-1:0]   p2_rdata_q;
    logic                sel_p1_d;
    logic                sel_p2_d;
    logic                tmo_expire;

    // P1 wins when both grants are high; a grant without its request is ignored.
    assign sel_p1_d = (grant1 == BUS_GRANTED) && (p1_req == BUS_REQUESTED);
    assign sel_p2_d = (grant2 == BUS_GRANTED) && (p2_req == BUS_REQUESTED);

`ifdef BUS_TIMEOUT_EN
    logic bus_err_q;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != ST_WAIT),
        .enable_i (state_q == ST_WAIT),
        .expire_o (tmo_expire)
    );

    assign bus_err = bus_err_q;
`else
    assign tmo_expire = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            arb_enable_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p1_ack_q     <= 1'b0;
            p2_ack_q     <= 1'b0;
            p1_rdata_q   <= '0;
            p2_rdata_q   <= '0;
`ifdef BUS_TIMEOUT_EN
            bus_err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; only the state that
            // owns the pulse raises it, so every pulse lasts exactly one cycle.
            mem_req_q <= 1'b0;
            p1_ack_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            bus_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (sel_p1_d || sel_p2_d) begin
                        owner_q      <= sel_p1_d ? OWN_P1 : OWN_P2;
                        mem_we_q     <= sel_p1_d ? p1_we    : p2_we;
                        mem_addr_q   <= sel_p1_d ? p1_addr  : p2_addr;
                        mem_wdata_q  <= sel_p1_d ? p1_wdata : p2_wdata;
                        mem_req_q    <= 1'b1;
                        arb_enable_q <= 1'b0;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready on the expiring cycle still completes normally.
                    if (mem_ready || tmo_expire) begin
                        if (mem_ready && !mem_we_q) begin
                            if (owner_q == OWN_P1) p1_rdata_q <= mem_rdata;
                            else                   p2_rdata_q <= mem_rdata;
                        end
                        p1_ack_q <= (owner_q == OWN_P1);
                        p2_ack_q <= (owner_q == OWN_P2);
`ifdef BUS_TIMEOUT_EN
                        bus_err_q <= !mem_ready;
`endif
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    owner_q      <= OWN_NONE;
                    arb_enable_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_enable = arb_enable_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign p1_ack     = p1_ack_q;
    assign p2_ack     = p2_ack_q;
    assign p1_rdata   = p1_rdata_q;
    assign p2_rdata   = p2_rdata_q;
    assign bus_owner  = owner_q;

endmodule

// File: tb/tb_shared_bus_controller.sv
// Self-checking bench for shared_bus_controller: table-driven transactions with a
// command/response scoreboard, plus hand-written arbitration, reset and timeout cases.
module tb_shared_bus_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        grant1, grant2, arb_enable;
    logic        p1_req, p2_req, p1_we, p2_we;
    logic [7:0]  p1_addr, p2_addr;
    logic [15:0] p1_wdata, p2_wdata;
    logic        p1_ack, p2_ack;
    logic [15:0] p1_rdata, p2_rdata;
    logic        bus_err, mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [1:0]  bus_owner;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_bus_controller #(
        .ADDR_W (8),
        .DATA_W (16)
`ifdef BUS_TIMEOUT_EN
        ,
        .TIMEOUT (4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .grant1     (grant1),
        .grant2     (grant2),
        .arb_enable (arb_enable),
        .p1_req     (p1_req),
        .p2_req     (p2_req),
        .p1_we      (p1_we),
        .p2_we      (p2_we),
        .p1_addr    (p1_addr),
        .p2_addr    (p2_addr),
        .p1_wdata   (p1_wdata),
        .p2_wdata   (p2_wdata),
        .p1_ack     (p1_ack),
        .p2_ack     (p2_ack),
        .p1_rdata   (p1_rdata),
        .p2_rdata   (p2_rdata),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .bus_owner  (bus_owner)
    );

    typedef struct {
        logic [1:0]  owner;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          port;
        logic        both_grants;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] mem_data;
        logic        ready_in_issue;
        logic        toggle_in_wait;
        int          exp_cycle;
        logic [15:0] exp_rdata;
    } vec_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    cmd_t  mon_cmd;
    resp_t mon_resp;
    vec_t  vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory-side and requester-side monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_mem_req", 1, 0);
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check("cmd_owner", bus_owner, mon_cmd.owner);
                    check("cmd_we", mem_we, mon_cmd.we);
                    check("cmd_addr", mem_addr, mon_cmd.addr);
                    check("cmd_wdata", mem_wdata, mon_cmd.wdata);
                end
            end
            if (p1_ack || p2_ack) begin
                check("ack_onehot", p1_ack & p2_ack, 0);
                if (resp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    mon_resp = resp_q.pop_front();
                    check("resp_port", p1_ack ? 1 : 2, mon_resp.port);
                    check("resp_rdata", p1_ack ? p1_rdata : p2_rdata, mon_resp.rdata);
                    check("resp_err", bus_err, mon_resp.err);
                end
            end
        end
    end

    task automatic clear_requests();
        p1_req = 1'b0; p2_req = 1'b0;
        grant1 = 1'b0; grant2 = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc;
        bit         acked;
        logic [1:0] exp_owner;
        exp_owner = (v.port == 1) ? 2'b01 : 2'b10;
        cmd_q.push_back('{owner: exp_owner, we: v.we, addr: v.addr, wdata: v.wdata});
        resp_q.push_back('{port: v.port, rdata: v.exp_rdata, err: 1'b0});
        if (v.port == 1) begin
            p1_req = 1'b1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
            grant1 = 1'b1; grant2 = v.both_grants;
        end else begin
            p2_req = 1'b1; p2_we = v.we; p2_addr = v.addr; p2_wdata = v.wdata;
            grant2 = 1'b1; grant1 = v.both_grants;
        end
        cyc   = 0;
        acked = 1'b0;
        while (!acked && cyc < 40) begin
            step();
            cyc++;
            mem_ready = 1'b0;
            if (cyc == 1) check("issue_mem_req", mem_req, 1);
            if (cyc == 2) check("wait_mem_req_low", mem_req, 0);
            check("busy_arb_enable", arb_enable, 0);
            check("busy_owner", bus_owner, exp_owner);
            check("held_addr", mem_addr, v.addr);
            check("held_we", mem_we, v.we);
            if (v.we) check("held_wdata", mem_wdata, v.wdata);
            if (cyc == 1 && v.ready_in_issue) begin
                mem_ready = 1'b1; mem_rdata = 16'h7777;
            end
            if (cyc == 2 && v.toggle_in_wait) begin
                p1_addr = ~v.addr; p1_we = ~v.we;
            end
            if (cyc == 2 + v.delay) begin
                mem_ready = 1'b1; mem_rdata = v.mem_data;
            end
            if (p1_ack || p2_ack) begin
                acked = 1'b1;
                check("ack_cycle", cyc, v.exp_cycle);
                clear_requests();
            end
        end
        if (!acked) begin
            check("ack_timeout", 0, 1);
            clear_requests();
        end
        step();
        check("idle_arb_enable", arb_enable, 1);
        check("idle_owner", bus_owner, 0);
        check("idle_no_ack", {p1_ack, p2_ack}, 0);
    endtask

    initial begin
        int         cyc;
        int         n_mreq;
        int         ready_at;
        int         req_cyc[2];
        logic [1:0] req_own[2];
        bit         p1_done, p2_done;

        vecs[0] = '{port: 1, both_grants: 0, we: 0, addr: 8'h3A, wdata: 16'h0000, delay: 0,
                    mem_data: 16'hBEEF, ready_in_issue: 0, toggle_in_wait: 0,
                    exp_cycle: 3, exp_rdata: 16'hBEEF};
        vecs[1] = '{port: 2, both_grants: 1, we: 1, addr: 8'h10, wdata: 16'h1234, delay: 3,
                    mem_data: 16'hDEAD, ready_in_issue: 0, toggle_in_wait: 0,
                    exp_cycle: 6, exp_rdata: 16'h0000};
        vecs[2] = '{port: 2, both_grants: 0, we: 0, addr: 8'h55, wdata: 16'h0F0F, delay: 1,
                    mem_data: 16'hA5A5, ready_in_issue: 0, toggle_in_wait: 0,
                    exp_cycle: 4, exp_rdata: 16'hA5A5};
        vecs[3] = '{port: 1, both_grants: 0, we: 1, addr: 8'hFF, wdata: 16'hFFFF, delay: 0,
                    mem_data: 16'h0BAD, ready_in_issue: 0, toggle_in_wait: 0,
                    exp_cycle: 3, exp_rdata: 16'hBEEF};
        vecs[4] = '{port: 1, both_grants: 0, we: 0, addr: 8'h00, wdata: 16'h0000, delay: 2,
                    mem_data: 16'h0001, ready_in_issue: 1, toggle_in_wait: 0,
                    exp_cycle: 5, exp_rdata: 16'h0001};
        vecs[5] = '{port: 2, both_grants: 0, we: 1, addr: 8'h80, wdata: 16'h0000, delay: 0,
                    mem_data: 16'h5555, ready_in_issue: 0, toggle_in_wait: 0,
                    exp_cycle: 3, exp_rdata: 16'hA5A5};
        vecs[6] = '{port: 1, both_grants: 0, we: 0, addr: 8'h22, wdata: 16'h0000, delay: 3,
                    mem_data: 16'hC3C3, ready_in_issue: 0, toggle_in_wait: 1,
                    exp_cycle: 6, exp_rdata: 16'hC3C3};

        reset = 1'b1;
        clear_requests();
        p1_we = 1'b0; p2_we = 1'b0;
        p1_addr = '0; p2_addr = '0; p1_wdata = '0; p2_wdata = '0;
        mem_rdata = '0;
        step();
        step();
        check("rst_arb_enable", arb_enable, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_acks", {p1_ack, p2_ack, bus_err}, 0);
        check("rst_rdata", {p1_rdata, p2_rdata}, 0);
        check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_owner", bus_owner, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Both cores request together: P1 first, P2 held until the next IDLE.
        cmd_q.push_back('{owner: 2'b01, we: 1'b0, addr: 8'h41, wdata: 16'h0000});
        cmd_q.push_back('{owner: 2'b10, we: 1'b1, addr: 8'h42, wdata: 16'h2222});
        resp_q.push_back('{port: 1, rdata: 16'h1111, err: 1'b0});
        resp_q.push_back('{port: 2, rdata: 16'hA5A5, err: 1'b0});
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h41; p1_wdata = 16'h0000;
        p2_req = 1'b1; p2_we = 1'b1; p2_addr = 8'h42; p2_wdata = 16'h2222;
        grant1 = 1'b1; grant2 = 1'b1;
        cyc = 0; n_mreq = 0; ready_at = -1;
        req_cyc[0] = 0; req_cyc[1] = 0; req_own[0] = '0; req_own[1] = '0;
        p1_done = 1'b0; p2_done = 1'b0;
        while (!(p1_done && p2_done) && cyc < 40) begin
            step();
            cyc++;
            mem_ready = 1'b0;
            if (mem_req) begin
                if (n_mreq < 2) begin
                    req_cyc[n_mreq] = cyc;
                    req_own[n_mreq] = bus_owner;
                end
                n_mreq++;
                ready_at = cyc + 1;
            end
            if (cyc == ready_at) begin
                mem_ready = 1'b1; mem_rdata = 16'h1111;
            end
            if (p1_ack) begin p1_req = 1'b0; p1_done = 1'b1; end
            if (p2_ack) begin p2_req = 1'b0; p2_done = 1'b1; end
        end
        check("both_completed", {p1_done, p2_done}, 2'b11);
        check("both_mem_req_count", n_mreq, 2);
        check("both_first_req_cycle", req_cyc[0], 1);
        check("both_owner_first", req_own[0], 2'b01);
        check("both_owner_second", req_own[1], 2'b10);
        check("both_req_spacing", req_cyc[1] - req_cyc[0], 4);
        clear_requests();
        step();

        // Reset while the transaction sits in WAIT abandons it.
        cmd_q.push_back('{owner: 2'b01, we: 1'b0, addr: 8'h3C, wdata: 16'h0000});
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h3C; grant1 = 1'b1;
        step();
        check("rstw_issue", mem_req, 1);
        step();
        check("rstw_in_wait", {mem_req, arb_enable, p1_ack}, 0);
        reset = 1'b1;
        step();
        check("rstw_mem_req", mem_req, 0);
        check("rstw_no_ack", {p1_ack, p2_ack}, 0);
        check("rstw_arb_enable", arb_enable, 1);
        check("rstw_owner", bus_owner, 0);
        check("rstw_rdata", p1_rdata, 0);
        reset = 1'b0;
        clear_requests();
        step();
        step();
        check("rstw_still_idle", {mem_req, p1_ack, arb_enable}, 3'b001);
        run_vec(vecs[0]);

`ifdef BUS_TIMEOUT_EN
        // mem_ready never arrives: abort after exactly four WAIT cycles.
        cmd_q.push_back('{owner: 2'b01, we: 1'b0, addr: 8'h07, wdata: 16'h0000});
        resp_q.push_back('{port: 1, rdata: 16'hBEEF, err: 1'b1});
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h07; grant1 = 1'b1;
        mem_rdata = 16'h6666;
        cyc = 0; p1_done = 1'b0;
        while (!p1_done && cyc < 40) begin
            step();
            cyc++;
            if (p1_ack) begin
                p1_done = 1'b1;
                check("tmo_ack_cycle", cyc, 6);
                check("tmo_bus_err", bus_err, 1);
                check("tmo_rdata_kept", p1_rdata, 16'hBEEF);
                clear_requests();
            end
        end
        check("tmo_completed", p1_done, 1);
        clear_requests();
        step();
        check("tmo_err_pulse", bus_err, 0);
`endif

        step();
        step();
        check("cmd_queue_drained", cmd_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
